// File: rtl/rv_lsu_if.sv
// Request/grant/response data-memory bus between rv_lsu (master) and the memory system (slave).
interface rv_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req_o;
  logic                  bus_gnt_i;
  logic                  bus_we_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [3:0]            bus_be_o;
  logic [DATA_WIDTH-1:0] bus_wdata_o;
  logic                  bus_rvalid_i;
  logic [DATA_WIDTH-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/rv_lsu.sv
// RV32I load/store unit: one bus transaction per core access, lane steering and load extension.
// Define LSU_TIMEOUT_EN to build in the bus watchdog (limit TIMEOUT_CYCLES).
module rv_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_stall_o,
  output logic                  lsu_done_o,
  output logic                  lsu_err_o,
  rv_lsu_if.master              bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, DONE} state_t;

  state_t                state_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            offset_reg;
  logic                  legal;
  logic                  timeout;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] load_data;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [7:0]            rbyte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rlane
      assign rbyte[gi] = bus.bus_rdata_i[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    legal = 1'b0;
    case (lsu_funct3_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~lsu_addr_i[0];
      3'b010:  legal = (lsu_addr_i[1:0] == 2'b00);
      3'b100:  legal = ~lsu_we_i;
      3'b101:  legal = ~lsu_we_i & ~lsu_addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Narrow stores replicate their data across lanes so the byte enables alone pick the target.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = lsu_wdata_i;
    if (lsu_we_i) begin
      case (lsu_funct3_i[1:0])
        2'b00: begin
          be_next    = 4'b0001 << lsu_addr_i[1:0];
          wdata_next = {4{lsu_wdata_i[7:0]}};
        end
        2'b01: begin
          be_next    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{lsu_wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_byte = rbyte[offset_reg];
    lane_half = offset_reg[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
      3'b001:  load_data = {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane_half};
      default: load_data = bus.bus_rdata_i;
    endcase
  end

  assign lsu_stall_o = lsu_req_i & legal & (state_reg != DONE);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;

  // Cleared in IDLE and on the REQ->WAIT_RV hop, so each waiting state starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg == IDLE || (state_reg == REQ && bus.bus_gnt_i)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout = (state_reg == REQ || state_reg == WAIT_RV) &&
                   (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
  // The watchdog limit only matters when the watchdog is compiled in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      funct3_reg      <= 3'b000;
      offset_reg      <= 2'b00;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= '0;
      bus.bus_be_o    <= 4'b0000;
      bus.bus_wdata_o <= '0;
      lsu_rdata_o     <= '0;
      lsu_done_o      <= 1'b0;
      lsu_err_o       <= 1'b0;
    end else begin
      lsu_done_o <= 1'b0;
      lsu_err_o  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (lsu_req_i && legal) begin
            bus.bus_req_o   <= 1'b1;
            bus.bus_we_o    <= lsu_we_i;
            bus.bus_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus.bus_be_o    <= be_next;
            bus.bus_wdata_o <= wdata_next;
            funct3_reg      <= lsu_funct3_i;
            offset_reg      <= lsu_addr_i[1:0];
            state_reg       <= REQ;
          end else if (lsu_req_i) begin
            lsu_err_o   <= 1'b1;
            lsu_rdata_o <= '0;
          end
        end
        REQ: begin
          if (bus.bus_gnt_i) begin
            bus.bus_req_o <= 1'b0;
            state_reg     <= WAIT_RV;
          end else if (timeout) begin
            bus.bus_req_o <= 1'b0;
            lsu_rdata_o   <= '0;
            lsu_done_o    <= 1'b1;
            lsu_err_o     <= 1'b1;
            state_reg     <= DONE;
          end
        end
        WAIT_RV: begin
          if (bus.bus_rvalid_i) begin
            lsu_rdata_o <= bus.bus_we_o ? '0 : load_data;
            lsu_done_o  <= 1'b1;
            state_reg   <= DONE;
          end else if (timeout) begin
            lsu_rdata_o <= '0;
            lsu_done_o  <= 1'b1;
            lsu_err_o   <= 1'b1;
            state_reg   <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed self-checking bench for rv_lsu; a small bus responder issues gnt/rvalid after set delays.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  rv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu_req_i    (lsu_req),
    .lsu_we_i     (lsu_we),
    .lsu_funct3_i (lsu_funct3),
    .lsu_addr_i   (lsu_addr),
    .lsu_wdata_i  (lsu_wdata),
    .lsu_rdata_o  (lsu_rdata),
    .lsu_stall_o  (lsu_stall),
    .lsu_done_o   (lsu_done),
    .lsu_err_o    (lsu_err),
    .bus          (bus)
  );

  typedef struct {
    logic [31:0] rd;
    int          stall_cnt;
    int          done_cyc;
    int          req_start;
    logic        err;
    logic        held;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } txn_res_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with the DUT in IDLE; returns in the DONE cycle (or after the budget).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rword, output txn_res_t r);
    int   req_cycles = 0;
    int   wait_cycles = 0;
    logic granted = 1'b0;
    r = '{rd: 32'h0, stall_cnt: 0, done_cyc: -1, req_start: -1, err: 1'b0, held: 1'b1,
          addr: 32'h0, be: 4'h0, wdata: 32'h0, we: 1'b0};
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    for (int cyc = 0; cyc < 100 && r.done_cyc < 0; cyc++) begin
      bus.bus_gnt_i = 1'b0;
      bus.bus_rvalid_i = 1'b0;
      if (lsu_done) begin
        r.done_cyc = cyc; r.rd = lsu_rdata; r.err = lsu_err;
      end else if (bus.bus_req_o) begin
        if (req_cycles == 0) begin
          r.req_start = cyc; r.addr = bus.bus_addr_o; r.be = bus.bus_be_o;
          r.wdata = bus.bus_wdata_o; r.we = bus.bus_we_o;
        end else if (bus.bus_addr_o !== r.addr || bus.bus_be_o !== r.be ||
                     bus.bus_wdata_o !== r.wdata || bus.bus_we_o !== r.we) begin
          r.held = 1'b0;
        end
        if (req_cycles == gnt_wait) begin
          bus.bus_gnt_i = 1'b1; granted = 1'b1;
        end
        req_cycles++;
      end else if (granted) begin
        if (wait_cycles == rv_wait) begin
          bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = rword;
        end
        wait_cycles++;
      end
      #1;
      if (lsu_stall) r.stall_cnt++;
      if (r.done_cyc < 0) step();
    end
    lsu_req = 1'b0; bus.bus_gnt_i = 1'b0; bus.bus_rvalid_i = 1'b0;
    $display("txn we=%0d f3=%0d addr=%h -> bus_addr=%h be=%b wdata=%h rdata=%h err=%0d stall=%0d done_cyc=%0d",
             we, f3, addr, r.addr, r.be, r.wdata, r.rd, r.err, r.stall_cnt, r.done_cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b0; lsu_addr = 32'h0;
    lsu_wdata = 32'h0; bus.bus_gnt_i = 1'b0; bus.bus_rvalid_i = 1'b0; bus.bus_rdata_i = 32'h0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.bus_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, want 0", bus.bus_req_o); end
    checks++; if (bus.bus_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, want 0", bus.bus_addr_o); end
    checks++; if ({bus.bus_we_o, bus.bus_be_o} !== 5'b0) begin errors++; $display("FAIL reset_we_be: got %b, want 0", {bus.bus_we_o, bus.bus_be_o}); end
    checks++; if (bus.bus_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h, want 0", bus.bus_wdata_o); end
    checks++; if ({lsu_rdata, lsu_done, lsu_err, lsu_stall} !== 35'h0) begin errors++; $display("FAIL reset_core: rdata=%h done=%b err=%b stall=%b, want all 0", lsu_rdata, lsu_done, lsu_err, lsu_stall); end
    $display("txn reset released");
    step();
  endtask

  task automatic test_load_word();
    txn_res_t r;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, r);
    checks++; if (r.addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h, want 00000100", r.addr); end
    checks++; if (r.be !== 4'b1111 || r.we !== 1'b0) begin errors++; $display("FAIL lw_be_we: got be=%b we=%b, want 1111/0", r.be, r.we); end
    checks++; if (r.stall_cnt !== 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d, want 3", r.stall_cnt); end
    checks++; if (r.req_start !== 1 || r.done_cyc !== 3) begin errors++; $display("FAIL lw_latency: got req@%0d done@%0d, want 1/3", r.req_start, r.done_cyc); end
    checks++; if (r.rd !== 32'hDEADBEEF || r.err !== 1'b0) begin errors++; $display("FAIL lw_rdata: got %h err=%b, want deadbeef err=0", r.rd, r.err); end
    step();
    checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse: done still %b one cycle later, want 0", lsu_done); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3_t  [8] = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b101, 3'b101, 3'b000};
    logic [31:0] adr_t [8] = '{32'h103, 32'h103, 32'h102, 32'h101, 32'h102, 32'h100, 32'h102, 32'h100};
    logic [31:0] exp_t [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h00000012,
                               32'hFFFF80FF, 32'h00001234, 32'h000080FF, 32'h00000034};
    txn_res_t r;
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, f3_t[i], adr_t[i], 32'h0, 0, 0, 32'h80FF1234, r);
      checks++; if (r.rd !== exp_t[i]) begin errors++; $display("FAIL load_ext[%0d]: got %h, want %h", i, r.rd, exp_t[i]); end
      checks++; if (r.addr !== 32'h100 || r.be !== 4'b1111) begin errors++; $display("FAIL load_ext_bus[%0d]: got addr=%h be=%b, want 00000100/1111", i, r.addr, r.be); end
      step();
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3_t  [5] = '{3'b001, 3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] adr_t [5] = '{32'h202, 32'h301, 32'h200, 32'h404, 32'h300};
    logic [31:0] wd_t  [5] = '{32'h0000ABCD, 32'h123456EF, 32'hFFFF1357, 32'hCAFEF00D, 32'h99887766};
    logic [31:0] ba_t  [5] = '{32'h200, 32'h300, 32'h200, 32'h404, 32'h300};
    logic [3:0]  be_t  [5] = '{4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b0001};
    logic [31:0] bw_t  [5] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h13571357, 32'hCAFEF00D, 32'h66666666};
    txn_res_t r;
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b1, f3_t[i], adr_t[i], wd_t[i], 0, 0, 32'h55555555, r);
      checks++; if (r.addr !== ba_t[i] || r.be !== be_t[i]) begin errors++; $display("FAIL store_bus[%0d]: got addr=%h be=%b, want %h/%b", i, r.addr, r.be, ba_t[i], be_t[i]); end
      checks++; if (r.wdata !== bw_t[i] || r.we !== 1'b1) begin errors++; $display("FAIL store_wdata[%0d]: got %h we=%b, want %h we=1", i, r.wdata, r.we, bw_t[i]); end
      checks++; if (r.done_cyc !== 3 || r.rd !== 32'h0 || r.err !== 1'b0) begin errors++; $display("FAIL store_done[%0d]: got done@%0d rdata=%h err=%b, want 3/0/0", i, r.done_cyc, r.rd, r.err); end
      step();
    end
  endtask

  task automatic test_illegal();
    logic        we_t  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t  [6] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b010, 3'b110};
    logic [31:0] adr_t [6] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h201, 32'h100};
    txn_res_t r;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h11111111, r);
    step();
    for (int i = 0; i < 6; i++) begin
      lsu_req = 1'b1; lsu_we = we_t[i]; lsu_funct3 = f3_t[i]; lsu_addr = adr_t[i]; lsu_wdata = 32'h0;
      #1;
      checks++; if (lsu_stall !== 1'b0) begin errors++; $display("FAIL illegal_stall[%0d]: got %b, want 0", i, lsu_stall); end
      step();
      lsu_req = 1'b0;
      $display("txn illegal we=%0d f3=%0d addr=%h -> err=%0d rdata=%h bus_req=%0d", we_t[i], f3_t[i], adr_t[i], lsu_err, lsu_rdata, bus.bus_req_o);
      checks++; if (lsu_err !== 1'b1 || lsu_done !== 1'b0) begin errors++; $display("FAIL illegal_err[%0d]: got err=%b done=%b, want 1/0", i, lsu_err, lsu_done); end
      checks++; if (bus.bus_req_o !== 1'b0 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL illegal_bus[%0d]: got req=%b rdata=%h, want 0/0", i, bus.bus_req_o, lsu_rdata); end
      step();
      checks++; if (lsu_err !== 1'b0 || bus.bus_req_o !== 1'b0) begin errors++; $display("FAIL illegal_pulse[%0d]: got err=%b req=%b, want 0/0", i, lsu_err, bus.bus_req_o); end
    end
  endtask

  task automatic test_back_to_back();
    txn_res_t r;
    run_txn(1'b0, 3'b010, 32'h500, 32'h0, 5, 2, 32'h13579BDF, r);
    checks++; if (r.held !== 1'b1 || r.addr !== 32'h500) begin errors++; $display("FAIL slow_held: got held=%b addr=%h, want 1/00000500", r.held, r.addr); end
    checks++; if (r.stall_cnt !== 10 || r.done_cyc !== 10) begin errors++; $display("FAIL slow_stall: got stall=%0d done@%0d, want 10/10", r.stall_cnt, r.done_cyc); end
    checks++; if (r.rd !== 32'h13579BDF) begin errors++; $display("FAIL slow_rdata: got %h, want 13579bdf", r.rd); end
    step();
    run_txn(1'b1, 3'b010, 32'h504, 32'hA5A50F0F, 0, 0, 32'h0, r);
    checks++; if (r.req_start !== 1 || r.done_cyc !== 3) begin errors++; $display("FAIL b2b_latency: got req@%0d done@%0d, want 1/3", r.req_start, r.done_cyc); end
    checks++; if (r.addr !== 32'h504 || r.be !== 4'b1111 || r.wdata !== 32'hA5A50F0F || r.we !== 1'b1) begin errors++; $display("FAIL b2b_bus: got addr=%h be=%b wdata=%h we=%b, want 00000504/1111/a5a50f0f/1", r.addr, r.be, r.wdata, r.we); end
    step();
  endtask

  task automatic test_reset_mid_txn();
    txn_res_t r;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0F0F0F0F, r);
    step();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h600; lsu_wdata = 32'h77777777;
    step();
    bus.bus_gnt_i = 1'b1;
    step();
    bus.bus_gnt_i = 1'b0; rst_n = 1'b0; lsu_req = 1'b0;
    step();
    rst_n = 1'b1;
    $display("txn reset in WAIT_RV -> req=%0d addr=%h be=%b wdata=%h rdata=%h", bus.bus_req_o, bus.bus_addr_o, bus.bus_be_o, bus.bus_wdata_o, lsu_rdata);
    checks++; if (bus.bus_addr_o !== 32'h0 || bus.bus_wdata_o !== 32'h0) begin errors++; $display("FAIL midrst_bus: got addr=%h wdata=%h, want 0/0", bus.bus_addr_o, bus.bus_wdata_o); end
    checks++; if ({bus.bus_req_o, bus.bus_we_o, bus.bus_be_o} !== 6'b0) begin errors++; $display("FAIL midrst_ctl: got req/we/be=%b, want 0", {bus.bus_req_o, bus.bus_we_o, bus.bus_be_o}); end
    checks++; if ({lsu_rdata, lsu_done, lsu_err} !== 34'h0) begin errors++; $display("FAIL midrst_core: got rdata=%h done=%b err=%b, want 0", lsu_rdata, lsu_done, lsu_err); end
    bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'hFFFFFFFF;
    step();
    bus.bus_rvalid_i = 1'b0;
    checks++; if (lsu_done !== 1'b0 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL stale_rvalid: got done=%b rdata=%h, want 0/0", lsu_done, lsu_rdata); end
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h2468ACE0, r);
    checks++; if (r.req_start !== 1 || r.done_cyc !== 3 || r.rd !== 32'h2468ACE0) begin errors++; $display("FAIL post_reset_lw: got req@%0d done@%0d rdata=%h, want 1/3/2468ace0", r.req_start, r.done_cyc, r.rd); end
    step();
  endtask

  task automatic test_watchdog();
    txn_res_t r;
    run_txn(1'b0, 3'b010, 32'h700, 32'h0, 20, 0, 32'h3C3C3C3C, r);
    checks++; if (bus.bus_req_o !== 1'b0) begin errors++; $display("FAIL wd_req_in_done: got %b, want 0", bus.bus_req_o); end
`ifdef LSU_TIMEOUT_EN
    checks++; if (r.done_cyc !== 9 || r.stall_cnt !== 9) begin errors++; $display("FAIL wd_timeout_cycle: got done@%0d stall=%0d, want 9/9", r.done_cyc, r.stall_cnt); end
    checks++; if (r.err !== 1'b1 || r.rd !== 32'h0) begin errors++; $display("FAIL wd_timeout_err: got err=%b rdata=%h, want 1/0", r.err, r.rd); end
`else
    checks++; if (r.done_cyc !== 23 || r.stall_cnt !== 23) begin errors++; $display("FAIL wd_long_wait: got done@%0d stall=%0d, want 23/23", r.done_cyc, r.stall_cnt); end
    checks++; if (r.err !== 1'b0 || r.rd !== 32'h3C3C3C3C) begin errors++; $display("FAIL wd_long_rdata: got err=%b rdata=%h, want 0/3c3c3c3c", r.err, r.rd); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_stores();
    test_illegal();
    test_back_to_back();
    test_reset_mid_txn();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit directly downstream of the single-cycle core's data-memory port.
- Converts each core load/store into one request/grant/response bus transaction.
- Generates byte enables and store-data lane replication, and aligns and sign/zero-extends load data.
- Holds the core with a stall while the transaction is outstanding; detects misaligned and illegal accesses.

Parameters:
- DATA_WIDTH, 32, data width. Fixed at 32; other values are unsupported.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lsu_req_i  in  1  core requests a memory access (MemRead or MemWrite). Held stable while lsu_stall_o=1.
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- lsu_addr_i  in  ADDR_WIDTH  byte address (ALU result)
- lsu_wdata_i  in  DATA_WIDTH  store data (rs2)
- lsu_rdata_o  out  DATA_WIDTH  extended load data, valid while lsu_done_o=1
- lsu_stall_o  out  1  freeze PC/regfile write
- lsu_done_o  out  1  one-cycle completion pulse
- lsu_err_o  out  1  one-cycle error pulse
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  request accepted
- bus_we_o  out  1  write
- bus_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0]=0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  DATA_WIDTH  lane-replicated store data
- bus_rvalid_i  in  1  response (read data or write ack)
- bus_rdata_i  in  DATA_WIDTH  read word

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All registered outputs clear to 0: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, lsu_rdata_o, lsu_done_o, lsu_err_o.
- lsu_stall_o (combinational) = lsu_req_i & legal & (state != DONE).
- legal = funct3 is valid for the direction and the address is aligned:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=0;
  - funct3 3/6/7, and store funct3 4/5, are illegal.
- IDLE:
  - lsu_req_i & legal: register bus_addr_o = {addr[ADDR_WIDTH-1:2],2'b00}, bus_we_o, bus_be_o, bus_wdata_o, funct3 and addr[1:0]. Go to REQ.
  - lsu_req_i & !legal: pulse lsu_err_o for one cycle, lsu_rdata_o = 0, no bus activity, no stall. The core completes the instruction.
- Byte enables and store data:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111.
- REQ:
  - bus_req_o=1; address, we, be and wdata are held stable.
  - bus_gnt_i=1: bus_req_o drops to 0 next cycle; go to WAIT_RV.
- WAIT_RV:
  - bus_rvalid_i=1: register lsu_rdata_o; go to DONE.
  - Stores ignore bus_rdata_i and give lsu_rdata_o = 0.
  - rvalid is ignored in every other state, including a stale response after reset.
- Load extraction:
  - LB: sign-extend byte at lane addr[1:0]. LBU: zero-extend that byte.
  - LH: sign-extend half at lane addr[1]. LHU: zero-extend that half.
  - LW: full word.
- DONE:
  - lsu_done_o=1 and lsu_stall_o=0, so the core retires on this edge.
  - Next state is IDLE unconditionally.
  - A back-to-back request is accepted in the following IDLE cycle.
- Latency: with gnt in the first REQ cycle and rvalid in the first WAIT_RV cycle, stall is high for 3 cycles and done is asserted in cycle 3 after the request.
- Only one transaction is ever outstanding.
- A mid-transaction reset abandons the transfer. The bus must tolerate a dropped request.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - A counter runs in REQ and WAIT_RV and clears on state entry.
  - On reaching TIMEOUT_CYCLES, go to DONE with lsu_err_o=1, lsu_done_o=1, lsu_rdata_o=0 and bus_req_o=0.
- When undefined:
  - No counter exists and the unit waits indefinitely.
  - lsu_err_o reflects only illegal or misaligned accesses.

Test Plan:
- LW at addr 0x100, gnt in first REQ cycle, rvalid next cycle with 0xDEADBEEF -> bus_addr_o=0x100, be=1111, stall high 3 cycles, done with rdata 0xDEADBEEF.
- LB at 0x103 and LBU at 0x103 with bus word 0x80FF1234 -> 0xFFFFFF80 and 0x00000080.
- SH of 0x0000ABCD at 0x202 -> bus_addr 0x200, be=1100, wdata 0xABCDABCD, we=1, done after write ack.
- LW at 0x102 -> lsu_err_o pulse, bus_req_o never asserts, stall stays 0.
- gnt withheld 5 cycles, then rvalid after 2 further cycles -> request and address held stable throughout; stall asserted until done; back-to-back SW accepted the cycle after done.
- Reset asserted in WAIT_RV, then late rvalid -> all outputs 0, state IDLE, rvalid ignored. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no gnt -> err and done together after 8 cycles.
